// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: status and control signals between the lock
// supervisor, its clock synthesizer and the downstream logic.
// The supervisor drives everything except the synthesizer's lock flag.
//
// Signalling: there is no valid/ready handshake on this interface. Every
// signal is a level. "ready" is a status level that means "the supervisor is
// in RUNNING"; it does not acknowledge a transfer. "locked" comes straight
// from the synthesizer and is asynchronous to the reference clock.
interface pll_lock_supervisor_if;
    logic       locked;         // lock flag from the synthesizer (async)
    logic       pll_reset;      // synthesizer RST pin, active high
    logic       system_reset;   // downstream reset, high until lock qualified
    logic       ready;          // high only in RUNNING
    logic [1:0] state;          // 0=RESET_PLL 1=WAIT_LOCK 2=STABILIZE 3=RUNNING
    logic [7:0] timeout_count;  // WAIT_LOCK timeouts, saturating
    logic [7:0] loss_count;     // lock losses from RUNNING, saturating

    // Supervisor side.
    modport master (
        input  locked,
        output pll_reset,
        output system_reset,
        output ready,
        output state,
        output timeout_count,
        output loss_count
    );

    // Environment side: the synthesizer and the downstream consumer.
    modport slave (
        output locked,
        input  pll_reset,
        input  system_reset,
        input  ready,
        input  state,
        input  timeout_count,
        input  loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences a clock synthesizer (PLL/DCM) from the
// free-running reference clock that also feeds it. The synthesizer is held in
// reset, lock is awaited with a timeout, lock is qualified for a stable
// period and only then is the downstream system reset released. A loss of
// lock while running re-initializes the synthesizer.
//
// Optional feature macro: PLL_LOCK_GLITCH_FILTER_EN
//   undefined (default): one low cycle of synchronized lock in RUNNING is a
//                        lock loss; FILTER_CYCLES has no effect on behaviour.
//   defined:             lock loss needs FILTER_CYCLES consecutive low cycles
//                        of synchronized lock; shorter dips are ignored.
//
// Reset is asynchronous and active high. Its release is not synchronized
// here; it must come from a synchronous-release source.
module pll_lock_supervisor #(
    parameter int RESET_CYCLES  = 4,     // pll_reset high cycles per attempt
    parameter int LOCK_TIMEOUT  = 1024,  // WAIT_LOCK cycles before re-attempt
    parameter int STABLE_CYCLES = 256,   // consecutive lock cycles to release
    parameter int FILTER_CYCLES = 4      // low cycles that mean lock loss
) (
    input  logic                  clockin,
    input  logic                  reset,
    pll_lock_supervisor_if.master pls
);

    // The single cycle counter is sized to hold the largest terminal count
    // of any parameter, so no terminal compare can ever be unreachable.
    localparam int MAX_AB = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (STABLE_CYCLES > FILTER_CYCLES) ? STABLE_CYCLES : FILTER_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_RUNNING   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        sync_q;
    logic              locked_sync;
    logic              lock_loss;
    logic              timeout_hit;
    logic              loss_hit;
    logic [7:0]        timeout_cnt_q;
    logic [7:0]        loss_cnt_q;

    // Two-flop synchronizer bringing the asynchronous lock flag into clockin.
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pls.locked};
        end
    end

    assign locked_sync = sync_q[1];

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int FILT_W = $clog2(FILTER_CYCLES) + 1;
    localparam logic [FILT_W-1:0] FILTER_LAST = FILT_W'(FILTER_CYCLES - 1);

    logic [FILT_W-1:0] filt_q;

    // Run length of consecutive low lock cycles while RUNNING. Outside
    // RUNNING it is held at zero, so every entry to RUNNING starts clean.
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            filt_q <= '0;
        end else if (state_q != ST_RUNNING || locked_sync) begin
            filt_q <= '0;
        end else if (!lock_loss) begin
            filt_q <= filt_q + FILT_W'(1);
        end
    end

    // Loss is declared on the FILTER_CYCLES-th consecutive low cycle.
    assign lock_loss = !locked_sync && (filt_q == FILTER_LAST);
`else
    // Without filtering, any single low cycle of lock counts as a loss.
    assign lock_loss = !locked_sync;
`endif

    // State register.
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET_PLL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the one-cycle event strobes for the statistics.
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        loss_hit    = 1'b0;
        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RESET_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the very last timeout cycle still wins.
                if (locked_sync) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_RESET_PLL;
                    timeout_hit = 1'b1;
                end
            end
            ST_STABILIZE: begin
                // A dip here only restarts the wait; it is not a loss event.
                if (!locked_sync) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (lock_loss) begin
                    state_d  = ST_RESET_PLL;
                    loss_hit = 1'b1;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase
    end

    // Cycle counter: zero on every state change, counts otherwise. It holds
    // at all-ones so a long RUNNING stay cannot wrap it back into a terminal
    // count.
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Saturating count of WAIT_LOCK timeouts.
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            timeout_cnt_q <= 8'd0;
        end else if (timeout_hit && timeout_cnt_q != 8'hFF) begin
            timeout_cnt_q <= timeout_cnt_q + 8'd1;
        end
    end

    // Saturating count of lock losses out of RUNNING.
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            loss_cnt_q <= 8'd0;
        end else if (loss_hit && loss_cnt_q != 8'hFF) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    // All outputs decode directly from registers, so they change with the
    // asynchronous reset and never glitch on lock input activity.
    assign pls.pll_reset     = (state_q == ST_RESET_PLL);
    assign pls.system_reset  = (state_q != ST_RUNNING);
    assign pls.ready         = (state_q == ST_RUNNING);
    assign pls.state         = state_q;
    assign pls.timeout_count = timeout_cnt_q;
    assign pls.loss_count    = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: randomized and directed stimulus on the lock input,
// a behavioural reference model that predicts every output after every
// clock edge, and a negedge monitor that compares against the queued
// predictions. Honours PLL_LOCK_GLITCH_FILTER_EN like the design.
module tb_pll_lock_supervisor;

    localparam int RC = 4;
    localparam int LT = 16;
    localparam int SC = 8;
    localparam int FC = 4;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int LOSS_LEN = FC;
`else
    localparam int LOSS_LEN = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pll_lock_supervisor_if pif ();

    pll_lock_supervisor #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .FILTER_CYCLES (FC)
    ) dut (
        .clockin (clk),
        .reset   (reset),
        .pls     (pif.master)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase numbering follows the published state encoding. dwell counts how
    // many edges have already been spent in the current phase.
    int   m_phase;
    int   m_dwell;
    int   m_low_run;
    int   m_tcnt;
    int   m_lcnt;
    logic m_hist[$];   // lock samples still in flight to the sync output

    // {state, pll_reset, system_reset, ready, timeout_count, loss_count}
    logic [20:0] exp_q[$];

    function automatic logic [20:0] pack(input int ph, input int tc, input int lc);
        logic [1:0] s;
        s = 2'(ph);
        return {s, logic'(ph == 0), logic'(ph != 3), logic'(ph == 3), 8'(tc), 8'(lc)};
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_dwell   = 0;
        m_low_run = 0;
        m_tcnt    = 0;
        m_lcnt    = 0;
        m_hist    = {1'b0, 1'b0};
    endtask

    // Advance the model by one reference edge where the DUT sampled lock=l.
    task automatic model_step(input logic l, input logic r);
        logic ls;
        int   nxt;
        if (r) begin
            model_reset();
        end else begin
            ls = m_hist.pop_front();   // lock as seen two edges ago
            m_hist.push_back(l);
            nxt = m_phase;
            case (m_phase)
                0: if (m_dwell + 1 >= RC) nxt = 1;
                1: begin
                    if (ls) nxt = 2;
                    else if (m_dwell + 1 >= LT) begin
                        nxt = 0;
                        if (m_tcnt < 255) m_tcnt++;
                    end
                end
                2: begin
                    if (!ls) nxt = 1;
                    else if (m_dwell + 1 >= SC) nxt = 3;
                end
                default: begin
                    m_low_run = ls ? 0 : m_low_run + 1;
                    if (m_low_run >= LOSS_LEN) begin
                        nxt = 0;
                        if (m_lcnt < 255) m_lcnt++;
                    end
                end
            endcase
            if (nxt != m_phase) begin
                m_phase   = nxt;
                m_dwell   = 0;
                m_low_run = 0;
            end else begin
                m_dwell++;
            end
        end
        exp_q.push_back(pack(m_phase, m_tcnt, m_lcnt));
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; drives inputs, lets one rising edge happen,
    // records the prediction, and returns on the next falling edge.
    task automatic step(input logic l, input logic r);
        #2;
        reset      = r;
        pif.locked = l;
        @(posedge clk);
        model_step(l, r);
        @(negedge clk);
    endtask

    task automatic drive(input logic l, input int n);
        for (int i = 0; i < n; i++) step(l, 1'b0);
    endtask

    task automatic sync_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    // Assert reset between edges and check the outputs react before any edge.
    task automatic async_reset_check();
        #2;
        reset = 1'b1;
        #1;
        check("async_pll_reset",     pif.pll_reset,     1);
        check("async_system_reset",  pif.system_reset,  1);
        check("async_ready",         pif.ready,         0);
        check("async_state",         pif.state,         0);
        check("async_timeout_count", pif.timeout_count, 0);
        check("async_loss_count",    pif.loss_count,    0);
        @(posedge clk);
        model_step(pif.locked, 1'b1);
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [20:0] exp_v;
        logic [20:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {pif.state, pif.pll_reset, pif.system_reset, pif.ready,
                     pif.timeout_count, pif.loss_count};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got st=%0d pr=%b sr=%b rdy=%b to=%0d lo=%0d expected st=%0d pr=%b sr=%b rdy=%b to=%0d lo=%0d",
                         $time, act_v[20:19], act_v[18], act_v[17], act_v[16], act_v[15:8], act_v[7:0],
                         exp_v[20:19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:8], exp_v[7:0]);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        pif.locked = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #2;
        check("reset_state",         pif.state,         0);
        check("reset_pll_reset",     pif.pll_reset,     1);
        check("reset_system_reset",  pif.system_reset,  1);
        check("reset_ready",         pif.ready,         0);
        check("reset_timeout_count", pif.timeout_count, 0);
        check("reset_loss_count",    pif.loss_count,    0);
        @(negedge clk);
        sync_reset();

        // Clean bring-up with lock high: RUNNING after edge 13.
        for (int e = 1; e <= 20; e++) begin
            step(1'b1, 1'b0);
            if (e == 4)  check("bringup_wait_at_4",   pif.state, 1);
            if (e == 5)  check("bringup_stab_at_5",   pif.state, 2);
            if (e == 12) check("bringup_stab_at_12",  pif.state, 2);
            if (e == 13) check("bringup_run_at_13",   pif.state, 3);
            if (e == 13) check("bringup_sysrst_at_13", pif.system_reset, 0);
        end

        // Glitch in the middle of STABILIZE: returns to WAIT_LOCK, no counts.
        sync_reset();
        drive(1'b1, 8);
        drive(1'b0, 1);
        drive(1'b1, 30);
        check("stab_glitch_running",  pif.state,         3);
        check("stab_glitch_timeouts", pif.timeout_count, 0);
        check("stab_glitch_losses",   pif.loss_count,    0);

        // Single-attempt loss behaviour from RUNNING.
`ifdef PLL_LOCK_GLITCH_FILTER_EN
        drive(1'b0, LOSS_LEN - 1);
        drive(1'b1, 10);
        check("short_dip_still_running", pif.state,      3);
        check("short_dip_no_loss",       pif.loss_count, 0);
`endif
        drive(1'b0, LOSS_LEN);
        drive(1'b1, 3);
        check("loss_state",        pif.state,        0);
        check("loss_system_reset", pif.system_reset, 1);
        check("loss_count_one",    pif.loss_count,   1);
        drive(1'b1, 24);
        check("loss_recovered", pif.state, 3);

        // Two more losses, then an asynchronous reset while RUNNING.
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, LOSS_LEN);
            drive(1'b1, 24);
        end
        check("pre_async_loss3", pif.loss_count, 3);
        async_reset_check();
        step(1'b1, 1'b1);
        drive(1'b1, 20);

        // Lock never arrives: timeouts every RC+LT edges, saturating at 255.
        sync_reset();
        drive(1'b0, 260 * (RC + LT));
        check("timeout_saturated", pif.timeout_count, 255);

        // Lock-loss saturation.
        sync_reset();
        for (int k = 0; k < 258; k++) begin
            drive(1'b1, 24);
            drive(1'b0, LOSS_LEN);
        end
        drive(1'b1, 24);
        check("loss_saturated", pif.loss_count, 255);

        // Randomized lock behaviour with occasional resets.
        sync_reset();
        for (int seg = 0; seg < 200; seg++) begin
            drive(1'b1, $urandom_range(1, 40));
            drive(1'b0, $urandom_range(1, 6));
            if ($urandom_range(0, 19) == 0) sync_reset();
        end
        drive(1'b1, 30);

        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
